johnson_seq_ctrl: RTL and testbench
===================================

// Module: johnson_seq_ctrl
// PURPOSE
//  Controller that owns and sequences a WIDTH-bit Johnson (twisted-ring) counter.
//  Runs a programmed number of steps in either direction, single-steps, aborts,
//  loads a start pattern, and detects/repairs illegal ring codes. Phase sequencer
//  for multi-phase enables; downstream logic consumes out/phase.
// PARAMETERS
//  WIDTH  4  ring width; 2*WIDTH legal states
//  CNT_W  8  width of step-count request
// PORTS
//  clk        in   1                     clock, all state on rising edge
//  rst_n      in   1                     asynchronous, active-low reset
//  start      in   1                     begin run of num_steps steps (IDLE only)
//  num_steps  in   CNT_W                 steps to run, sampled with start
//  dir        in   1                     0=forward, 1=reverse; sampled with start/step
//  step       in   1                     advance one position (IDLE only)
//  stop       in   1                     abort run in progress
//  load       in   1                     load load_val into ring (IDLE only)
//  load_val   in   WIDTH                 pattern to load
//  clr_err    in   1                     clear sticky err
//  out        out  WIDTH                 ring value (registered)
//  phase      out  $clog2(2*WIDTH)       position 0..2*WIDTH-1, combinational from out
//  busy       out  1                     high while in RUN
//  done       out  1                     1-cycle pulse, run completed
//  aborted    out  1                     1-cycle pulse, run stopped early
//  err        out  1                     sticky: illegal load pattern seen
// BEHAVIOUR
//  - Reset (rst_n=0, async): out=0, busy=0, done=0, aborted=0, err=0, state IDLE.
//    Reset mid-run abandons run immediately; no done/aborted pulse.
//  - Forward advance: out <= {out[W-2:0], ~out[W-1]}; reverse: out <= {~out[0], out[W-1:1]}.
//  - phase: out[W-1]==0 -> popcount(out); else 2*WIDTH - popcount(out). Forward = +1 mod 2W,
//    reverse = -1 mod 2W; wraps 2W-1<->0 freely.
//  - Legal code: out == 2^k-1 or ~out == 2^k-1 (k=0..WIDTH). Only these 2W values appear on out.
//  - FSM states: IDLE, RUN.
//  - IDLE priority: load > start > step (one action per cycle).
//    load: legal load_val -> out=load_val next edge; illegal -> out=0, err=1.
//    start, num_steps>0: latch num_steps into remaining, latch dir, -> RUN, busy=1; no advance on this edge.
//    start, num_steps==0: stay IDLE, out unchanged, done=1 for next cycle.
//    step: advance one position in dir at next edge; no done pulse.
//  - RUN: each edge advance one position (latched dir), remaining--. On edge where remaining==1:
//    advance, -> IDLE, busy=0, done=1 for one cycle. N steps => out changes on edges E1..EN after
//    start edge E0; busy high E0..EN; done high in cycle after EN.
//  - stop in RUN: priority over advance; next edge no advance, -> IDLE, busy=0, aborted=1 one cycle,
//    done not asserted. stop in IDLE ignored. stop and final step same cycle -> aborted, no advance.
//  - start, step, load, dir changes while busy: ignored.
//  - remaining width CNT_W; max run 2^CNT_W-1 steps.
//  - err: set by illegal load, cleared by clr_err; set wins over clr_err same cycle.
// TESTING
//  1 reset, start N=5 dir=0 -> out 0001,0011,0111,1111,1110 on E1..E5; done pulse; phase=5.
//  2 from 0000, start N=3 dir=1 -> out 1000,1100,1110; phase 7,6,5; done once.
//  3 start N=10 dir=0 from 0000 -> wraps; final out=0011, phase=2; busy high 11 cycles.
//  4 start N=8, stop after 3rd advance -> out 0111 held, aborted=1, done=0; start during run ignored.
//  5 load 0101 -> out=0000, err=1; clr_err -> err=0; load 1100 -> out=1100, phase=6; start N=0 -> done, out unchanged.
//  6 rst_n low mid-run (async, between edges) -> out=0, busy=0 immediately; step after release -> 0001.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer: programmed runs, single steps, abort, pattern load with
// illegal-code detection. Outputs registered except phase, which decodes out.
module johnson_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   localparam int PH_W = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_steps,
   input  logic             dir,
   input  logic             step,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   output logic [WIDTH-1:0] out,
   output logic [PH_W-1:0]  phase,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] remaining;
   logic             run_dir;
   logic [PH_W:0]    ones;

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v, input logic rev);
      if (rev)
         return {~v[0], v[WIDTH-1:1]};
      else
         return {v[WIDTH-2:0], ~v[WIDTH-1]};
   endfunction

   // Legal codes are a solid run of ones from the LSB, or the complement of one.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      logic [WIDTH:0] m;
      logic           ok;
      ok = 1'b0;
      for (int k = 0; k <= WIDTH; k++) begin
         m = (WIDTH+1)'((1 << k) - 1);
         if ((v == m[WIDTH-1:0]) || (~v == m[WIDTH-1:0]))
            ok = 1'b1;
      end
      return ok;
   endfunction

   always_comb begin
      ones = '0;
      for (int i = 0; i < WIDTH; i++)
         ones = ones + (PH_W+1)'(out[i]);
      if (out[WIDTH-1])
         phase = PH_W'((PH_W+1)'(2*WIDTH) - ones);
      else
         phase = PH_W'(ones);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out       <= '0;
         remaining <= '0;
         run_dir   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         err       <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         if (clr_err)
            err <= 1'b0;

         case (state)
            IDLE: begin
               if (load) begin
                  if (is_legal(load_val)) begin
                     out <= load_val;
                  end else begin
                     out <= '0;
                     err <= 1'b1;
                  end
               end else if (start) begin
                  if (num_steps != '0) begin
                     remaining <= num_steps;
                     run_dir   <= dir;
                     busy      <= 1'b1;
                     state     <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end else if (step) begin
                  out <= advance(out, dir);
               end
            end

            RUN: begin
               // An abort outranks the advance, including on the final step.
               if (stop) begin
                  busy    <= 1'b0;
                  aborted <= 1'b1;
                  state   <= IDLE;
               end else begin
                  out       <= advance(out, run_dir);
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl; expected cycle results are queued, then
// popped and compared after each clock edge.
module tb_johnson_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, dir, step, stop, load, clr_err;
   logic [7:0] num_steps;
   logic [3:0] load_val;
   logic [3:0] out;
   logic [2:0] phase;
   logic       busy, done, aborted, err;

   typedef struct {
      logic [3:0] out;
      logic [2:0] phase;
      logic       busy;
      logic       done;
      logic       aborted;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] seq [0:7];
   int         n_cmp = 0;
   int         n_err = 0;

   johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps), .dir(dir),
      .step(step), .stop(stop), .load(load), .load_val(load_val), .clr_err(clr_err),
      .out(out), .phase(phase), .busy(busy), .done(done), .aborted(aborted), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int pos, input bit b, input bit d, input bit a, input bit e);
      exp_t x;
      x.out     = seq[pos % 8];
      x.phase   = 3'(pos % 8);
      x.busy    = b;
      x.done    = d;
      x.aborted = a;
      x.err     = e;
      sb.push_back(x);
   endtask

   task automatic check_front(input string tag);
      exp_t x;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd0, 8'd1);
      end else begin
         x = sb.pop_front();
         chk({tag, "_out"},     8'(out),     8'(x.out));
         chk({tag, "_phase"},   8'(phase),   8'(x.phase));
         chk({tag, "_busy"},    8'(busy),    8'(x.busy));
         chk({tag, "_done"},    8'(done),    8'(x.done));
         chk({tag, "_aborted"}, 8'(aborted), 8'(x.aborted));
         chk({tag, "_err"},     8'(err),     8'(x.err));
      end
   endtask

   task automatic idle_inputs();
      start = 0; step = 0; stop = 0; load = 0; clr_err = 0;
   endtask

   // Push the state expected after the coming edge, clock once, then compare.
   task automatic cyc(input string tag, input int pos, input bit b, input bit d, input bit a, input bit e);
      push_exp(pos, b, d, a, e);
      @(posedge clk);
      #1;
      idle_inputs();
      check_front(tag);
   endtask

   initial begin
      seq[0] = 4'b0000; seq[1] = 4'b0001; seq[2] = 4'b0011; seq[3] = 4'b0111;
      seq[4] = 4'b1111; seq[5] = 4'b1110; seq[6] = 4'b1100; seq[7] = 4'b1000;
      idle_inputs();
      dir = 0; num_steps = 0; load_val = 0;
      rst_n = 0;
      #23;
      push_exp(0, 0, 0, 0, 0);
      check_front("reset");
      rst_n = 1;
      @(posedge clk); #1;

      // Forward run of 5
      start = 1; num_steps = 5; dir = 0;
      cyc("t1_e0", 0, 1, 0, 0, 0);
      for (int i = 1; i <= 5; i++)
         cyc($sformatf("t1_e%0d", i), i, i < 5, i == 5, 0, 0);
      cyc("t1_after", 5, 0, 0, 0, 0);

      // Reverse run of 3 from 0000
      load = 1; load_val = 4'b0000;
      cyc("t2_load", 0, 0, 0, 0, 0);
      start = 1; num_steps = 3; dir = 1;
      cyc("t2_e0", 0, 1, 0, 0, 0);
      dir = 0;
      for (int i = 1; i <= 3; i++)
         cyc($sformatf("t2_e%0d", i), 8 - i, i < 3, i == 3, 0, 0);
      cyc("t2_after", 5, 0, 0, 0, 0);

      // Wrapping run of 10
      load = 1; load_val = 4'b0000;
      cyc("t3_load", 0, 0, 0, 0, 0);
      start = 1; num_steps = 10; dir = 0;
      cyc("t3_e0", 0, 1, 0, 0, 0);
      for (int i = 1; i <= 10; i++)
         cyc($sformatf("t3_e%0d", i), i, i < 10, i == 10, 0, 0);
      cyc("t3_after", 2, 0, 0, 0, 0);

      // Abort after third advance; run-time commands ignored
      load = 1; load_val = 4'b0000;
      cyc("t4_load", 0, 0, 0, 0, 0);
      start = 1; num_steps = 8; dir = 0;
      cyc("t4_e0", 0, 1, 0, 0, 0);
      cyc("t4_e1", 1, 1, 0, 0, 0);
      start = 1; num_steps = 0; step = 1; dir = 1; load = 1; load_val = 4'b1111;
      cyc("t4_e2_ignored", 2, 1, 0, 0, 0);
      cyc("t4_e3", 3, 1, 0, 0, 0);
      stop = 1;
      cyc("t4_stop", 3, 0, 0, 1, 0);
      cyc("t4_after", 3, 0, 0, 0, 0);
      stop = 1;
      cyc("t4_stop_idle", 3, 0, 0, 0, 0);

      // Stop coincident with final step
      start = 1; num_steps = 2; dir = 0;
      cyc("t4b_e0", 3, 1, 0, 0, 0);
      cyc("t4b_e1", 4, 1, 0, 0, 0);
      stop = 1;
      cyc("t4b_stop_last", 4, 0, 0, 1, 0);

      // Illegal load, error clear, set-over-clear, legal load, zero-length run
      load = 1; load_val = 4'b0101;
      cyc("t5_illegal", 0, 0, 0, 0, 1);
      clr_err = 1;
      cyc("t5_clr", 0, 0, 0, 0, 0);
      load = 1; load_val = 4'b1011; clr_err = 1;
      cyc("t5_set_wins", 0, 0, 0, 0, 1);
      clr_err = 1;
      cyc("t5_clr2", 0, 0, 0, 0, 0);
      load = 1; load_val = 4'b1100;
      cyc("t5_load_legal", 6, 0, 0, 0, 0);
      start = 1; num_steps = 0;
      cyc("t5_n0", 6, 0, 1, 0, 0);
      cyc("t5_n0_after", 6, 0, 0, 0, 0);
      step = 1; dir = 1;
      cyc("t5_step_rev", 5, 0, 0, 0, 0);
      load = 1; load_val = 4'b1000;
      cyc("t5_load_1000", 7, 0, 0, 0, 0);
      step = 1; dir = 0;
      cyc("t5_step_wrap_fwd", 0, 0, 0, 0, 0);
      step = 1; dir = 1;
      cyc("t5_step_wrap_rev", 7, 0, 0, 0, 0);

      // Asynchronous reset mid-run
      load = 1; load_val = 4'b0000;
      cyc("t6_load", 0, 0, 0, 0, 0);
      start = 1; num_steps = 8; dir = 0;
      cyc("t6_e0", 0, 1, 0, 0, 0);
      cyc("t6_e1", 1, 1, 0, 0, 0);
      cyc("t6_e2", 2, 1, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      push_exp(0, 0, 0, 0, 0);
      check_front("t6_async_rst");
      #1 rst_n = 1;
      cyc("t6_idle", 0, 0, 0, 0, 0);
      step = 1; dir = 0;
      cyc("t6_step", 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
